// File: rtl/standoff_pkg.sv
// Shared types for the standoff reaction game.
// State encoding is visible on the state output, so the values are fixed.
package standoff_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_HOLD      = 3'd2,
    S_DRAW      = 3'd3,
    S_RESULT    = 3'd4,
    S_GAME_OVER = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    M_NORMAL = 2'd0,
    M_DEMO   = 2'd1,
    M_SIM    = 2'd2
  } mode_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  localparam logic [1:0] FOUL_P1  = 2'b01;
  localparam logic [1:0] FOUL_P2  = 2'b10;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // x^8+x^6+x^5+x^4+1, Fibonacci form; primitive, so a non-zero seed never reaches zero
  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

endpackage

// File: rtl/standoff_tick_gen.sv
// Game tick divider: one-cycle tick every TICK_DIV clocks, or SIM_DIV when sim=1.
// Ports: clk, reset (sync, active high), pause (freezes counter), sim (divider
// select), tick (1-cycle pulse, never asserted while paused).
module standoff_tick_gen #(
  parameter int TICK_DIV = 50000000,
  parameter int SIM_DIV  = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pause,
  input  logic sim,
  output logic tick
);

  localparam int MAXD = (TICK_DIV > SIM_DIV) ? TICK_DIV : SIM_DIV;
  localparam int CW   = $clog2(MAXD) + 1;

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_last;
  logic          w_wrap;

  assign w_last = sim ? CW'(SIM_DIV - 1) : CW'(TICK_DIV - 1);
  // >= rather than == so a switch to the shorter divider never overruns
  assign w_wrap = (r_cnt >= w_last);
  assign tick   = w_wrap & ~pause;

  always_ff @(posedge clk) begin
    if (reset)       r_cnt <= '0;
    else if (!pause) r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
  end

endmodule

// File: rtl/standoff_round_ctrl.sv
// Two-player reaction game controller: countdown, random hold, draw window,
// foul/win scoring and game-over detection.
// Ports: clk, reset (sync, active high); start/pause/mode selects/p1_btn/p2_btn
// level inputs; draw, count (thermometer), winner, foul, p1_score, p2_score,
// game_over, state outputs.
module standoff_round_ctrl
  import standoff_pkg::*;
#(
  parameter int TICK_DIV     = 50000000,
  parameter int SIM_DIV      = 4,
  parameter int CD_NORMAL    = 3,
  parameter int CD_DEMO      = 7,
  parameter int CD_SIM       = 1,
  parameter int REACT_TICKS  = 3,
  parameter int RESULT_TICKS = 2,
  parameter int WIN_SCORE    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       normal,
  input  logic       demo,
  input  logic       simulation,
  input  logic       p1_btn,
  input  logic       p2_btn,
  output logic       draw,
  output logic [6:0] count,
  output logic [1:0] winner,
  output logic [1:0] foul,
  output logic [2:0] p1_score,
  output logic [2:0] p2_score,
  output logic       game_over,
  output logic [2:0] state
);

  localparam logic [2:0] WIN = 3'(WIN_SCORE);

  state_t     r_state, w_state_n;
  mode_t      r_mode, w_mode_n, w_mode_sel;
  logic [7:0] r_lfsr;
  logic [2:0] r_cd, w_cd_n;
  logic [3:0] r_tmr, w_tmr_n;
  logic [1:0] r_winner, w_winner_n, r_foul, w_foul_n;
  logic [2:0] r_p1, w_p1_n, r_p2, w_p2_n;
  logic       r_start_q, r_p1_q, r_p2_q;
  logic       w_start_e, w_p1_e, w_p2_e, w_tick;

  function automatic logic [2:0] cd_len(input mode_t m);
    case (m)
      M_NORMAL: return 3'(CD_NORMAL);
      M_SIM:    return 3'(CD_SIM);
      default:  return 3'(CD_DEMO);
    endcase
  endfunction

  function automatic logic [2:0] sat_inc(input logic [2:0] s);
    return (s >= WIN) ? s : s + 3'd1;
  endfunction

  standoff_tick_gen #(.TICK_DIV(TICK_DIV), .SIM_DIV(SIM_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .pause (pause),
    .sim   (r_mode == M_SIM),
    .tick  (w_tick)
  );

  // Previous-level registers keep tracking during pause, so a rise that
  // happens while paused is absorbed instead of firing on release.
  assign w_start_e = start  & ~r_start_q & ~pause;
  assign w_p1_e    = p1_btn & ~r_p1_q    & ~pause;
  assign w_p2_e    = p2_btn & ~r_p2_q    & ~pause;

  assign w_mode_sel = demo ? M_DEMO : normal ? M_NORMAL : simulation ? M_SIM : M_DEMO;

  always_comb begin
    w_state_n  = r_state;
    w_mode_n   = r_mode;
    w_cd_n     = r_cd;
    w_tmr_n    = r_tmr;
    w_winner_n = r_winner;
    w_foul_n   = r_foul;
    w_p1_n     = r_p1;
    w_p2_n     = r_p2;
    if (!pause) begin
      case (r_state)
        S_IDLE, S_GAME_OVER: if (w_start_e) begin
          if (r_state == S_GAME_OVER) begin
            w_p1_n = 3'd0;
            w_p2_n = 3'd0;
          end
          w_mode_n   = w_mode_sel;
          w_cd_n     = cd_len(w_mode_sel);
          w_winner_n = WIN_NONE;
          w_foul_n   = 2'b00;
          w_state_n  = S_COUNTDOWN;
        end
        S_COUNTDOWN, S_HOLD: begin
          if (w_p1_e || w_p2_e) begin
            // early press: opponent scores unless both jumped together
            if (w_p1_e && w_p2_e) w_foul_n = FOUL_P1 | FOUL_P2;
            else if (w_p1_e) begin
              w_foul_n = FOUL_P1;
              w_p2_n   = sat_inc(r_p2);
            end else begin
              w_foul_n = FOUL_P2;
              w_p1_n   = sat_inc(r_p1);
            end
            w_cd_n    = 3'd0;
            w_tmr_n   = 4'(RESULT_TICKS);
            w_state_n = S_RESULT;
          end else if (w_tick) begin
            if (r_state == S_COUNTDOWN) begin
              if (r_cd <= 3'd1) begin
                w_cd_n    = 3'd0;
                w_tmr_n   = {1'b0, r_lfsr[2:0]} + 4'd1;
                w_state_n = S_HOLD;
              end else begin
                w_cd_n = r_cd - 3'd1;
              end
            end else if (r_tmr <= 4'd1) begin
              w_tmr_n   = 4'(REACT_TICKS);
              w_state_n = S_DRAW;
            end else begin
              w_tmr_n = r_tmr - 4'd1;
            end
          end
        end
        S_DRAW: begin
          if (w_p1_e || w_p2_e) begin
            if (w_p1_e && w_p2_e) w_winner_n = WIN_TIE;
            else if (w_p1_e) begin
              w_winner_n = WIN_P1;
              w_p1_n     = sat_inc(r_p1);
            end else begin
              w_winner_n = WIN_P2;
              w_p2_n     = sat_inc(r_p2);
            end
            w_tmr_n   = 4'(RESULT_TICKS);
            w_state_n = S_RESULT;
          end else if (w_tick) begin
            if (r_tmr <= 4'd1) begin
              w_winner_n = WIN_NONE;
              w_tmr_n    = 4'(RESULT_TICKS);
              w_state_n  = S_RESULT;
            end else begin
              w_tmr_n = r_tmr - 4'd1;
            end
          end
        end
        S_RESULT: if (w_tick) begin
          if (r_tmr <= 4'd1) begin
            if (r_p1 == WIN || r_p2 == WIN) begin
              w_state_n = S_GAME_OVER;
            end else begin
              w_cd_n     = cd_len(r_mode);
              w_winner_n = WIN_NONE;
              w_foul_n   = 2'b00;
              w_state_n  = S_COUNTDOWN;
            end
          end else begin
            w_tmr_n = r_tmr - 4'd1;
          end
        end
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    r_start_q <= start;
    r_p1_q    <= p1_btn;
    r_p2_q    <= p2_btn;
    if (reset) begin
      r_state  <= S_IDLE;
      r_mode   <= M_DEMO;
      r_lfsr   <= LFSR_SEED;
      r_cd     <= 3'd0;
      r_tmr    <= 4'd0;
      r_winner <= WIN_NONE;
      r_foul   <= 2'b00;
      r_p1     <= 3'd0;
      r_p2     <= 3'd0;
    end else begin
      r_state  <= w_state_n;
      r_mode   <= w_mode_n;
      r_cd     <= w_cd_n;
      r_tmr    <= w_tmr_n;
      r_winner <= w_winner_n;
      r_foul   <= w_foul_n;
      r_p1     <= w_p1_n;
      r_p2     <= w_p2_n;
      if (!pause) r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  // MSB-first thermometer: n remaining -> top n bits set
  assign count     = ~(7'h7F >> r_cd);
  assign draw      = (r_state == S_DRAW);
  assign game_over = (r_state == S_GAME_OVER);
  assign winner    = r_winner;
  assign foul      = r_foul;
  assign p1_score  = r_p1;
  assign p2_score  = r_p2;
  assign state     = r_state;

endmodule

// File: doc/standoff_round_ctrl.md
STANDOFF_ROUND_CTRL -- requirements
Module: standoff_round_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clocks per game tick (1 s at 50 MHz) in normal/demo mode.
REQ-002 Parameter SIM_DIV, default 4, clocks per game tick in simulation mode.
REQ-003 Parameter CD_NORMAL, default 3; CD_DEMO, default 7; CD_SIM, default 1; countdown length in ticks per mode.
REQ-004 Parameter REACT_TICKS, default 3, draw-window length in ticks.
REQ-005 Parameter RESULT_TICKS, default 2, result-display length in ticks.
REQ-006 Parameter WIN_SCORE, default 5, score that ends the game (max 7).
REQ-007 clk  in  1  single system clock; all logic on posedge clk.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 start  in  1  level; rising edge starts or restarts the game.
REQ-010 pause  in  1  level; freezes all timing while high.
REQ-011 normal, demo, simulation  in  1 each  mode selects.
REQ-012 p1_btn, p2_btn  in  1 each  debounced player buttons, level.
REQ-013 draw  out  1  high while the draw window is open.
REQ-014 count  out  7  countdown thermometer, MSB-first fill (n remaining -> n ones from bit 6 down).
REQ-015 winner  out  2  last round: 00 none, 01 P1, 10 P2, 11 tie.
REQ-016 foul  out  2  last round: bit0 P1 fouled, bit1 P2 fouled.
REQ-017 p1_score, p2_score  out  3 each  running scores.
REQ-018 game_over  out  1  high in GAME_OVER state.
REQ-019 state  out  3  current FSM state encoding.

Function
REQ-020 Inputs start, p1_btn, p2_btn SHALL be rising-edge detected internally; a button already high on state entry SHALL not register.
REQ-021 Mode SHALL be latched on start edge from IDLE or GAME_OVER; priority demo > normal > simulation; none asserted -> demo.
REQ-022 Tick SHALL be a 1-cycle pulse every TICK_DIV clocks (SIM_DIV in simulation mode); divider holds its value while pause=1.
REQ-023 While pause=1 the FSM, timers and edge detection SHALL hold; button edges during pause are discarded.
REQ-024 States: IDLE, COUNTDOWN, HOLD, DRAW, RESULT, GAME_OVER.
REQ-025 IDLE -> COUNTDOWN on start edge; cd loaded with mode countdown; count shows cd.
REQ-026 COUNTDOWN: cd decrements per tick; at cd=0 -> HOLD with delay = LFSR[2:0]+1 ticks (1..8).
REQ-027 Button edge in COUNTDOWN or HOLD = foul: opponent score +1, foul bit set, -> RESULT; both same cycle -> foul=11, no score change.
REQ-028 HOLD expiry -> DRAW, draw=1 starting the next cycle.
REQ-029 DRAW: first button edge wins, winner score +1, winner set, -> RESULT; both same cycle -> winner=11, no score; REACT_TICKS ticks with no press -> winner=00, -> RESULT.
REQ-030 winner and foul SHALL be cleared on entering COUNTDOWN and hold their values through RESULT.
REQ-031 RESULT lasts RESULT_TICKS ticks, then -> GAME_OVER if either score = WIN_SCORE, else -> COUNTDOWN (new round, same mode).
REQ-032 Scores saturate at WIN_SCORE; never wrap.
REQ-033 GAME_OVER: start edge clears scores, relatches mode, -> COUNTDOWN.
REQ-034 start edge in any other non-IDLE state SHALL be ignored.
REQ-035 LFSR: 8-bit, taps x^8+x^6+x^5+x^4+1, advances every unpaused clock, never all-zero.

Reset
REQ-036 reset SHALL force IDLE, all outputs 0, scores 0, divider 0, cd 0, mode demo, LFSR 8'hA5, edge-detect registers to current input levels.
REQ-037 reset mid-round SHALL abort immediately with no score update.

Structure
REQ-038 Package standoff_pkg SHALL hold state encoding (IDLE=0..GAME_OVER=5), mode encoding, winner/foul codes.
REQ-039 Tick divider SHALL be sub-module standoff_tick_gen (clk, reset, pause, sim, tick).

Verification
REQ-040 SIM_DIV=4, simulation, start; P1 press 1 cycle after draw rises -> winner=01, p1_score=1, RESULT.
REQ-041 P2 press during COUNTDOWN -> foul=10, p1_score+1, no draw pulse.
REQ-042 Both pressed same cycle in DRAW -> winner=11, scores unchanged.
REQ-043 No press in DRAW -> after 3 ticks winner=00, next round begins.
REQ-044 pause asserted 100 cycles mid-HOLD -> draw delayed exactly 100 cycles; presses ignored.
REQ-045 P1 wins 5 rounds -> game_over=1, p1_score=5; start edge -> scores 0, COUNTDOWN; reset mid-DRAW -> IDLE, draw=0.
